// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I writeback arbiter.
// Request bundle, arbiter states and the x0 constant.
package rv32i_pkg;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  typedef enum logic {
    PIPE_PRI,
    FORCE
  } arb_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/rv32i_wb_fifo.sv
// Small sync FIFO of writeback requests.
// Also reports which registers are targeted by buffered entries.
module rv32i_wb_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_req_t                  din,
  input  logic                     pop,
  output wb_req_t                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              busy_mask
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t        mem [DEPTH];
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [PW-1:0]  off;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];

  // Mask is rebuilt from live entries, so duplicates stay set after a pop.
  always_comb begin
    busy_mask = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rptr;
      if ({1'b0, off} < count) busy_mask[mem[i].rd] = 1'b1;
    end
  end

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// Register-file write port arbiter: pipeline first,
// auxiliary results buffered and drained via forced stalls.
module rv32i_wb_arbiter
  import rv32i_pkg::*;
#(
  parameter int AUX_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pipe_wb_en,
  input  logic [4:0]                   pipe_wb_reg,
  input  logic [31:0]                  pipe_wb_data,
  input  logic                         aux_valid,
  output logic                         aux_ready,
  input  logic [4:0]                   aux_reg,
  input  logic [31:0]                  aux_data,
  output logic                         stall_out,
  output logic                         rf_wb_en,
  output logic [4:0]                   rf_wb_reg,
  output logic [31:0]                  rf_wb_data,
  output logic                         df_wb_enable,
  output logic [4:0]                   df_wb_reg,
  output logic [31:0]                  df_wb_data,
  output logic [31:0]                  aux_busy_mask,
  output logic [$clog2(AUX_DEPTH):0]   aux_count
);

  localparam int CW = $clog2(AUX_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t    state;
  arb_state_t    state_n;
  logic [SW-1:0] starve;
  logic [SW-1:0] starve_n;
  logic          pipe_live;
  logic          push;
  logic          pop;
  logic          empty;
  wb_req_t       aux_req;
  wb_req_t       pipe_req;
  wb_req_t       head;
  wb_req_t       win;

  assign pipe_live = pipe_wb_en & (pipe_wb_reg != REG_X0);
  assign aux_ready = aux_count < CW'(AUX_DEPTH);
  assign push      = aux_valid & aux_ready & (aux_reg != REG_X0);
  assign empty     = aux_count == '0;
  assign aux_req   = '{en: 1'b1, rd: aux_reg, data: aux_data};
  assign pipe_req  = '{en: 1'b1, rd: pipe_wb_reg, data: pipe_wb_data};

  rv32i_wb_fifo #(
    .DEPTH (AUX_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .din       (aux_req),
    .pop       (pop),
    .head      (head),
    .count     (aux_count),
    .busy_mask (aux_busy_mask)
  );

  always_comb begin
    state_n  = state;
    starve_n = starve;
    win      = '0;
    pop      = 1'b0;
    unique case (state)
      PIPE_PRI: begin
        if (pipe_live) begin
          win = pipe_req;
          if (!empty) begin
            if (starve == SW'(STARVE_LIMIT - 1)) state_n = FORCE;
            else starve_n = starve + SW'(1);
          end
        end else if (!empty) begin
          win      = head;
          pop      = 1'b1;
          starve_n = '0;
        end
      end
      FORCE: begin
        // Pipeline presents a bubble here; its inputs are ignored.
        state_n  = PIPE_PRI;
        starve_n = '0;
        if (!empty) begin
          win = head;
          pop = 1'b1;
        end
      end
      default: state_n = PIPE_PRI;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PIPE_PRI;
      starve     <= '0;
      stall_out  <= 1'b0;
      rf_wb_en   <= 1'b0;
      rf_wb_reg  <= '0;
      rf_wb_data <= '0;
    end else begin
      state     <= state_n;
      starve    <= starve_n;
      stall_out <= state_n == FORCE;
      rf_wb_en  <= win.en;
      if (win.en) begin
        rf_wb_reg  <= win.rd;
        rf_wb_data <= win.data;
      end
    end
  end

  assign df_wb_enable = rf_wb_en;
  assign df_wb_reg    = rf_wb_reg;
  assign df_wb_data   = rf_wb_data;

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Directed bench for rv32i_wb_arbiter.
// Each task drives one scenario and checks hand-computed values.
module tb_rv32i_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pipe_wb_en = 1'b0;
  logic [4:0]  pipe_wb_reg = '0;
  logic [31:0] pipe_wb_data = '0;
  logic        aux_valid = 1'b0;
  logic        aux_ready;
  logic [4:0]  aux_reg = '0;
  logic [31:0] aux_data = '0;
  logic        stall_out;
  logic        rf_wb_en;
  logic [4:0]  rf_wb_reg;
  logic [31:0] rf_wb_data;
  logic        df_wb_enable;
  logic [4:0]  df_wb_reg;
  logic [31:0] df_wb_data;
  logic [31:0] aux_busy_mask;
  logic [1:0]  aux_count;

  int checks = 0;
  int errors = 0;

  rv32i_wb_arbiter #(
    .AUX_DEPTH    (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_wb_en    (pipe_wb_en),
    .pipe_wb_reg   (pipe_wb_reg),
    .pipe_wb_data  (pipe_wb_data),
    .aux_valid     (aux_valid),
    .aux_ready     (aux_ready),
    .aux_reg       (aux_reg),
    .aux_data      (aux_data),
    .stall_out     (stall_out),
    .rf_wb_en      (rf_wb_en),
    .rf_wb_reg     (rf_wb_reg),
    .rf_wb_data    (rf_wb_data),
    .df_wb_enable  (df_wb_enable),
    .df_wb_reg     (df_wb_reg),
    .df_wb_data    (df_wb_data),
    .aux_busy_mask (aux_busy_mask),
    .aux_count     (aux_count)
  );

  always #5 clk = ~clk;

  // Decode must never write a register with an aux result in flight.
  always @(negedge clk) begin
    if (reset && !stall_out && pipe_wb_en && pipe_wb_reg != 5'd0) begin
      checks++;
      if (aux_busy_mask[pipe_wb_reg] !== 1'b0) begin
        errors++;
        $display("FAIL order_contract reg %0d mask %08h", pipe_wb_reg, aux_busy_mask);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (rf_wb_en !== 1'b0) begin errors++; $display("FAIL rst_en got %0h exp 0", rf_wb_en); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h exp 0", stall_out); end
    checks++; if (aux_count !== 2'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", aux_count); end
    checks++; if (aux_busy_mask !== 32'h0) begin errors++; $display("FAIL rst_mask got %08h exp 0", aux_busy_mask); end
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0h exp 1", aux_ready); end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_pipe();
    pipe_wb_en = 1'b1; pipe_wb_reg = 5'd5; pipe_wb_data = 32'h1234;
    step();
    checks++; if (rf_wb_en !== 1'b1) begin errors++; $display("FAIL pipe_en got %0h exp 1", rf_wb_en); end
    checks++; if (rf_wb_reg !== 5'd5) begin errors++; $display("FAIL pipe_reg got %0d exp 5", rf_wb_reg); end
    checks++; if (rf_wb_data !== 32'h1234) begin errors++; $display("FAIL pipe_data got %08h exp 00001234", rf_wb_data); end
    checks++; if (df_wb_enable !== 1'b1) begin errors++; $display("FAIL df_en got %0h exp 1", df_wb_enable); end
    checks++; if (df_wb_reg !== 5'd5) begin errors++; $display("FAIL df_reg got %0d exp 5", df_wb_reg); end
    checks++; if (df_wb_data !== 32'h1234) begin errors++; $display("FAIL df_data got %08h exp 00001234", df_wb_data); end
    pipe_wb_reg = 5'd0; pipe_wb_data = 32'hFFFF;
    step();
    checks++; if (rf_wb_en !== 1'b0) begin errors++; $display("FAIL x0_en got %0h exp 0", rf_wb_en); end
    checks++; if (rf_wb_reg !== 5'd5) begin errors++; $display("FAIL x0_hold_reg got %0d exp 5", rf_wb_reg); end
    checks++; if (rf_wb_data !== 32'h1234) begin errors++; $display("FAIL x0_hold_data got %08h exp 00001234", rf_wb_data); end
    pipe_wb_en = 1'b0;
    step();
  endtask

  task automatic test_aux_single();
    aux_valid = 1'b1; aux_reg = 5'd7; aux_data = 32'hDEAD;
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL aux_ready got %0h exp 1", aux_ready); end
    step();
    aux_valid = 1'b0;
    checks++; if (aux_busy_mask !== 32'h80) begin errors++; $display("FAIL aux_mask got %08h exp 00000080", aux_busy_mask); end
    checks++; if (aux_count !== 2'd1) begin errors++; $display("FAIL aux_count got %0d exp 1", aux_count); end
    checks++; if (rf_wb_en !== 1'b0) begin errors++; $display("FAIL aux_nobypass got %0h exp 0", rf_wb_en); end
    step();
    checks++; if (rf_wb_en !== 1'b1) begin errors++; $display("FAIL aux_wr_en got %0h exp 1", rf_wb_en); end
    checks++; if (rf_wb_reg !== 5'd7) begin errors++; $display("FAIL aux_wr_reg got %0d exp 7", rf_wb_reg); end
    checks++; if (rf_wb_data !== 32'hDEAD) begin errors++; $display("FAIL aux_wr_data got %08h exp 0000dead", rf_wb_data); end
    checks++; if (aux_busy_mask !== 32'h0) begin errors++; $display("FAIL aux_mask_clr got %08h exp 0", aux_busy_mask); end
    step();
  endtask

  task automatic test_full();
    pipe_wb_en = 1'b1; pipe_wb_reg = 5'd10; pipe_wb_data = 32'hA0;
    aux_valid = 1'b1; aux_reg = 5'd3; aux_data = 32'h33;
    step();
    aux_reg = 5'd4; aux_data = 32'h44;
    step();
    aux_reg = 5'd5; aux_data = 32'h55;
    checks++; if (aux_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0h exp 0", aux_ready); end
    checks++; if (aux_count !== 2'd2) begin errors++; $display("FAIL full_count got %0d exp 2", aux_count); end
    checks++; if (aux_busy_mask !== 32'h18) begin errors++; $display("FAIL full_mask got %08h exp 00000018", aux_busy_mask); end
    step();
    checks++; if (aux_count !== 2'd2) begin errors++; $display("FAIL full_hold got %0d exp 2", aux_count); end
    pipe_wb_en = 1'b0;
    checks++; if (aux_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got %0h exp 0", aux_ready); end
    step();
    checks++; if (rf_wb_reg !== 5'd3) begin errors++; $display("FAIL full_pop1 got %0d exp 3", rf_wb_reg); end
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL full_ready2 got %0h exp 1", aux_ready); end
    step();
    aux_valid = 1'b0;
    checks++; if (rf_wb_reg !== 5'd4) begin errors++; $display("FAIL full_pop2 got %0d exp 4", rf_wb_reg); end
    checks++; if (aux_busy_mask !== 32'h20) begin errors++; $display("FAIL full_mask3 got %08h exp 00000020", aux_busy_mask); end
    step();
    checks++; if (rf_wb_data !== 32'h55) begin errors++; $display("FAIL full_third got %08h exp 00000055", rf_wb_data); end
    checks++; if (aux_count !== 2'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", aux_count); end
  endtask

  task automatic test_same_cycle();
    aux_valid = 1'b1; aux_reg = 5'd9; aux_data = 32'h1;
    step();
    aux_data = 32'h2;
    checks++; if (aux_busy_mask !== 32'h200) begin errors++; $display("FAIL same_mask0 got %08h exp 00000200", aux_busy_mask); end
    step();
    aux_valid = 1'b0;
    checks++; if (aux_busy_mask !== 32'h200) begin errors++; $display("FAIL same_mask got %08h exp 00000200", aux_busy_mask); end
    checks++; if (aux_count !== 2'd1) begin errors++; $display("FAIL same_count got %0d exp 1", aux_count); end
    checks++; if (rf_wb_data !== 32'h1) begin errors++; $display("FAIL same_first got %08h exp 00000001", rf_wb_data); end
    step();
    checks++; if (rf_wb_data !== 32'h2) begin errors++; $display("FAIL same_second got %08h exp 00000002", rf_wb_data); end
    checks++; if (aux_busy_mask !== 32'h0) begin errors++; $display("FAIL same_clr got %08h exp 0", aux_busy_mask); end
    step();
  endtask

  task automatic test_starve();
    pipe_wb_en = 1'b1; pipe_wb_reg = 5'd10; pipe_wb_data = 32'hA0;
    aux_valid = 1'b1; aux_reg = 5'd9; aux_data = 32'h99;
    step();
    aux_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL starve_early%0d got %0h exp 0", i, stall_out); end
    end
    step();
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL starve_stall got %0h exp 1", stall_out); end
    checks++; if (rf_wb_reg !== 5'd10) begin errors++; $display("FAIL starve_pipe got %0d exp 10", rf_wb_reg); end
    pipe_wb_reg = 5'd11; pipe_wb_data = 32'hBB;
    step();
    checks++; if (rf_wb_reg !== 5'd9) begin errors++; $display("FAIL force_reg got %0d exp 9", rf_wb_reg); end
    checks++; if (rf_wb_data !== 32'h99) begin errors++; $display("FAIL force_data got %08h exp 00000099", rf_wb_data); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL force_unstall got %0h exp 0", stall_out); end
    checks++; if (aux_count !== 2'd0) begin errors++; $display("FAIL force_count got %0d exp 0", aux_count); end
    step();
    checks++; if (rf_wb_reg !== 5'd11) begin errors++; $display("FAIL post_force got %0d exp 11", rf_wb_reg); end
    pipe_wb_en = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    pipe_wb_en = 1'b1; pipe_wb_reg = 5'd10; pipe_wb_data = 32'hA0;
    aux_valid = 1'b1; aux_reg = 5'd3;
    step();
    aux_reg = 5'd4;
    step();
    aux_valid = 1'b0; pipe_wb_en = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (aux_count !== 2'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", aux_count); end
    checks++; if (aux_busy_mask !== 32'h0) begin errors++; $display("FAIL mid_mask got %08h exp 0", aux_busy_mask); end
    checks++; if (rf_wb_en !== 1'b0) begin errors++; $display("FAIL mid_en got %0h exp 0", rf_wb_en); end
    checks++; if (rf_wb_reg !== 5'd0) begin errors++; $display("FAIL mid_reg got %0d exp 0", rf_wb_reg); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL mid_stall got %0h exp 0", stall_out); end
    #2;
    reset = 1'b1;
    step();
    checks++; if (rf_wb_en !== 1'b0) begin errors++; $display("FAIL mid_discard got %0h exp 0", rf_wb_en); end
  endtask

  initial begin
    test_reset();
    test_pipe();
    test_aux_single();
    test_full();
    test_same_cycle();
    test_starve();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
